ac_interval_coder: RTL

Interval-update and renormalization stage of the arithmetic encoder, directly downstream of the Newton-Raphson divider.

- Exports its current range to the divider.
- Accepts the quotient `step = range/total` plus the symbol's cumulative bounds, and narrows its `[low, high)` interval.
- Renormalizes with E1/E2/E3 scaling, emitting the serial code bitstream one bit at a time under valid/ready backpressure.
- Supports an end-of-stream flush.

---
 rtl/ac_interval_coder_if.sv | 23 ++
 rtl/ac_interval_coder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ac_interval_coder_if.sv
// ac_interval_coder_if: symbol/range exchange with the divider and serial code bit stream
interface ac_interval_coder_if;
    logic [15:0] range_out;
    logic [15:0] step;
    logic [15:0] cum_low;
    logic [15:0] cum_high;
    logic        sym_valid;
    logic        sym_ready;
    logic        flush;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        done;
    logic        error;
    modport master (
        input  range_out, sym_ready, bit_out, bit_valid, done, error,
        output sym_valid, step, cum_low, cum_high, flush, bit_ready
    );
    modport slave (
        output range_out, sym_ready, bit_out, bit_valid, done, error,
        input  sym_valid, step, cum_low, cum_high, flush, bit_ready
    );
endinterface

// File: rtl/ac_interval_coder.sv
// ac_interval_coder: arithmetic-coder interval narrowing with E1/E2/E3 renormalization and flush
module ac_interval_coder #(
    parameter int PEND_W = 16
) (
    input logic clk,
    input logic rst_n,
    ac_interval_coder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RENORM, EMIT, FLUSH, FLUSH_END} state_t;
    state_t state, state_n;
    logic [15:0] low, low_n, rng, rng_n;
    logic [16:0] high, high_n, span;
    logic [PEND_W-1:0] pend, pend_n;
    logic prim, prim_n, ret_fl, ret_fl_n, bit_q, bit_n, vld, vld_n, err, err_n;
    logic [31:0] p_lo, p_hi;
    logic bad;
    assign span = high - 17'(low);
    assign p_lo = 32'(bus.step) * 32'(bus.cum_low);
    assign p_hi = 32'(bus.step) * 32'(bus.cum_high);
    assign bad = (bus.step == 16'h0) || (bus.cum_high <= bus.cum_low) || (p_hi > 32'(span));
    always_comb begin
        state_n = state;
        low_n = low;
        high_n = high;
        pend_n = pend;
        prim_n = prim;
        ret_fl_n = ret_fl;
        bit_n = bit_q;
        vld_n = vld;
        err_n = err;
        rng_n = rng;
        case (state)
            IDLE: begin
                if (bus.flush) begin
                    state_n = FLUSH;
                end else if (bus.sym_valid) begin
                    if (bad) begin
                        err_n = 1'b1;
                    end else begin
                        low_n = low + 16'(p_lo);
                        high_n = 17'(low) + 17'(p_hi);
                        state_n = RENORM;
                    end
                end
            end
            RENORM: begin
                if (high <= 17'h08000) begin
                    prim_n = 1'b0;
                    bit_n = 1'b0;
                    vld_n = 1'b1;
                    ret_fl_n = 1'b0;
                    low_n = low << 1;
                    high_n = high << 1;
                    state_n = EMIT;
                end else if (low >= 16'h8000) begin
                    prim_n = 1'b1;
                    bit_n = 1'b1;
                    vld_n = 1'b1;
                    ret_fl_n = 1'b0;
                    low_n = (low - 16'h8000) << 1;
                    high_n = (high - 17'h08000) << 1;
                    state_n = EMIT;
                end else if (low >= 16'h4000 && high <= 17'h0C000) begin
                    pend_n = &pend ? pend : pend + 1'b1;
                    err_n = err | (&pend);
                    low_n = (low - 16'h4000) << 1;
                    high_n = (high - 17'h04000) << 1;
                end else begin
                    rng_n = span[16] ? 16'hFFFF : span[15:0];
                    state_n = IDLE;
                end
            end
            EMIT: begin
                if (bus.bit_ready) begin
                    if (pend != '0) begin
                        bit_n = ~prim;
                        pend_n = pend - 1'b1;
                    end else begin
                        vld_n = 1'b0;
                        state_n = ret_fl ? FLUSH_END : RENORM;
                    end
                end
            end
            FLUSH: begin
                pend_n = &pend ? pend : pend + 1'b1;
                err_n = err | (&pend);
                prim_n = low >= 16'h4000;
                bit_n = low >= 16'h4000;
                vld_n = 1'b1;
                ret_fl_n = 1'b1;
                state_n = EMIT;
            end
            FLUSH_END: begin
                low_n = 16'h0;
                high_n = 17'h10000;
                pend_n = '0;
                rng_n = 16'hFFFF;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            low <= 16'h0;
            high <= 17'h10000;
            pend <= '0;
            prim <= 1'b0;
            ret_fl <= 1'b0;
            bit_q <= 1'b0;
            vld <= 1'b0;
            err <= 1'b0;
            rng <= 16'hFFFF;
        end else begin
            state <= state_n;
            low <= low_n;
            high <= high_n;
            pend <= pend_n;
            prim <= prim_n;
            ret_fl <= ret_fl_n;
            bit_q <= bit_n;
            vld <= vld_n;
            err <= err_n;
            rng <= rng_n;
        end
    end
    assign bus.range_out = rng;
    assign bus.sym_ready = state == IDLE;
    assign bus.bit_out = bit_q;
    assign bus.bit_valid = vld;
    assign bus.done = state == FLUSH_END;
    assign bus.error = err;
endmodule
